fp_add_normalize: RTL and testbench

Second stage of the single-precision FP adder, directly downstream of the alignment stage. It takes the aligned 24-bit mantissas, the common exponent and the guard/round/sticky bits. It performs the effective add or subtract, normalizes iteratively (one bit per cycle), rounds to nearest-even and packs an IEEE-754 binary32 result. Transactions use a valid/ready handshake on both sides, so the multi-cycle normalize loop can stall the upstream stage.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_add_normalize_if.sv | 41 ++++
 rtl/fp_round_pack.sv | 51 +++++
 rtl/fp_add_normalize.sv | 169 ++++++++++++++++
 tb/tb_fp_add_normalize.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// fp_pkg
// Shared definitions for the binary32 adder normalize/round stage.
// Provides the FSM state enum, the field-width constants and a packed
// struct that overlays the IEEE-754 binary32 layout {sign, exp, frac}.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int EXT_W   = 27;
    localparam int EXP_MAX = 255;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        NORM,
        ROUND,
        DONE
    } fpState;

    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   exponent;
        logic [MAN_W-1:0]   fraction;
    } fpBinary32;

endpackage

// File: rtl/fp_add_normalize_if.sv
// fp_add_normalize_if
// Handshake bundle between the alignment stage, the normalize stage and the
// downstream consumer.
//   master : upstream/downstream side (drives operands, in_valid, out_ready)
//   slave  : the normalize stage (drives in_ready, out_valid, result, flags)
// Signals: in_valid/in_ready, signA, signB, exponentIn, alignedMantissaA/B,
// guardBit, roundBit, stickyBit, out_valid/out_ready, result, overflow, inexact.
interface fp_add_normalize_if;
    import fp_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               signA;
    logic               signB;
    logic [EXP_W-1:0]   exponentIn;
    logic [MAN_W:0]     alignedMantissaA;
    logic [MAN_W:0]     alignedMantissaB;
    logic               guardBit;
    logic               roundBit;
    logic               stickyBit;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        result;
    logic               overflow;
    logic               inexact;

    modport master (
        output in_valid, signA, signB, exponentIn,
               alignedMantissaA, alignedMantissaB,
               guardBit, roundBit, stickyBit, out_ready,
        input  in_ready, out_valid, result, overflow, inexact
    );

    modport slave (
        input  in_valid, signA, signB, exponentIn,
               alignedMantissaA, alignedMantissaB,
               guardBit, roundBit, stickyBit, out_ready,
        output in_ready, out_valid, result, overflow, inexact
    );

endinterface

// File: rtl/fp_round_pack.sv
// fp_round_pack
// Combinational round-to-nearest-even and binary32 packing.
// Ports:
//   sign     in   result sign
//   ext      in   27-bit extended mantissa, bit 26 hidden, bits [2:0] = G/R/S
//   expIn    in   9-bit internal exponent (never below 1)
//   result   out  packed binary32 word
//   overflow out  result saturated to infinity
//   inexact  out  any of G/R/S set before rounding
module fp_round_pack
    import fp_pkg::*;
(
    input  logic               sign,
    input  logic [EXT_W-1:0]   ext,
    input  logic [EXP_W:0]     expIn,
    output logic [31:0]        result,
    output logic               overflow,
    output logic               inexact
);

    logic              roundUp;
    logic [MAN_W+1:0]  rounded;
    logic [MAN_W:0]    mant;
    logic [EXP_W:0]    expAdj;
    fpBinary32         fields;

    // Round half to even, then absorb a mantissa carry by shifting right.
    // A denormal (E==1, hidden clear) that rounds into bit 23 becomes the
    // smallest normal purely through the hidden-bit test on the exponent.
    always_comb begin
        roundUp  = ext[2] & (ext[1] | ext[0] | ext[3]);
        rounded  = {1'b0, ext[EXT_W-1:3]} + {{MAN_W+1{1'b0}}, roundUp};
        mant     = rounded[MAN_W:0];
        expAdj   = expIn;
        if (rounded[MAN_W+1]) begin
            mant   = rounded[MAN_W+1:1];
            expAdj = expIn + 9'd1;
        end
        overflow        = (expAdj >= 9'(EXP_MAX));
        inexact         = |ext[2:0];
        fields.sign     = sign;
        fields.exponent = mant[MAN_W] ? expAdj[EXP_W-1:0] : 8'd0;
        fields.fraction = mant[MAN_W-1:0];
        if (overflow) begin
            fields.exponent = 8'hFF;
            fields.fraction = '0;
        end
        result = fields;
    end

endmodule

// File: rtl/fp_add_normalize.sv
// fp_add_normalize
// Second stage of the binary32 adder: effective add/subtract of the aligned
// mantissas, one-bit-per-cycle left normalization, RNE rounding and packing.
// Ports:
//   clock    in   single rising-edge clock
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of fp_add_normalize_if (operands, handshakes,
//            registered result/overflow/inexact)
module fp_add_normalize
    import fp_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    fp_add_normalize_if.slave bus
);

    fpState              state;
    fpState              stateNext;

    logic                signAQ;
    logic                signBQ;
    logic [EXP_W-1:0]    expQ;
    logic [MAN_W:0]      manAQ;
    logic [MAN_W:0]      manBQ;
    logic                gQ;
    logic                rQ;
    logic                sQ;

    logic [EXT_W-1:0]    extQ;
    logic [EXP_W:0]      eQ;
    logic                signQ;

    logic [31:0]         resultQ;
    logic                overflowQ;
    logic                inexactQ;
    logic                inReadyQ;
    logic                outValidQ;

    logic                aLarger;
    logic [EXT_W-1:0]    opX;
    logic [EXT_W-1:0]    opY;
    logic [EXP_W:0]      eBase;
    logic [EXT_W:0]      sum28;
    logic [EXT_W-1:0]    diff27;
    logic [EXT_W-1:0]    addExt;
    logic [EXP_W:0]      addE;
    logic                addSign;
    logic                addZero;
    logic [EXT_W-1:0]    normExt;
    logic [EXP_W:0]      normE;

    logic [31:0]         rpResult;
    logic                rpOverflow;
    logic                rpInexact;

    // Effective operation on the captured operands. The GRS bits always
    // belong to the smaller mantissa; equal mantissas carry zero GRS, so
    // X-Y never goes negative. A sum carry is folded back with the lost bit
    // ORed into the sticky position.
    always_comb begin
        aLarger = (manAQ >= manBQ);
        opX     = {aLarger ? manAQ : manBQ, 3'b000};
        opY     = {aLarger ? manBQ : manAQ, gQ, rQ, sQ};
        eBase   = (expQ == 8'd0) ? 9'd1 : {1'b0, expQ};
        sum28   = {1'b0, opX} + {1'b0, opY};
        diff27  = opX - opY;
        addExt  = sum28[EXT_W-1:0];
        addE    = eBase;
        addSign = signAQ;
        addZero = 1'b0;
        if (signAQ == signBQ) begin
            if (sum28[EXT_W]) begin
                addExt = {sum28[EXT_W:2], sum28[1] | sum28[0]};
                addE   = eBase + 9'd1;
            end
        end else begin
            addExt  = diff27;
            addSign = aLarger ? signAQ : signBQ;
            addZero = (diff27 == '0);
        end
        normExt = {extQ[EXT_W-2:0], 1'b0};
        normE   = eQ - 9'd1;
    end

    fp_round_pack roundPack (
        .sign     (signQ),
        .ext      (extQ),
        .expIn    (eQ),
        .result   (rpResult),
        .overflow (rpOverflow),
        .inexact  (rpInexact)
    );

    // Next-state logic. Normalization stops once the hidden bit is set or the
    // exponent reaches 1, which is where denormal results come from.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (bus.in_valid) stateNext = ADD;
            ADD: begin
                if (addZero)                          stateNext = DONE;
                else if (!addExt[EXT_W-1] && addE > 9'd1) stateNext = NORM;
                else                                  stateNext = ROUND;
            end
            NORM:  if (normExt[EXT_W-1] || normE == 9'd1) stateNext = ROUND;
            ROUND: stateNext = DONE;
            DONE:  if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, datapath and output registers. in_ready/out_valid are decoded
    // from the next state so every output comes straight from a flop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            resultQ   <= '0;
            overflowQ <= 1'b0;
            inexactQ  <= 1'b0;
        end else begin
            state     <= stateNext;
            inReadyQ  <= (stateNext == IDLE);
            outValidQ <= (stateNext == DONE);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        signAQ <= bus.signA;
                        signBQ <= bus.signB;
                        expQ   <= bus.exponentIn;
                        manAQ  <= bus.alignedMantissaA;
                        manBQ  <= bus.alignedMantissaB;
                        gQ     <= bus.guardBit;
                        rQ     <= bus.roundBit;
                        sQ     <= bus.stickyBit;
                    end
                end
                ADD: begin
                    extQ  <= addExt;
                    eQ    <= addE;
                    signQ <= addSign;
                    if (addZero) begin
                        resultQ   <= '0;
                        overflowQ <= 1'b0;
                        inexactQ  <= 1'b0;
                    end
                end
                NORM: begin
                    extQ <= normExt;
                    eQ   <= normE;
                end
                ROUND: begin
                    resultQ   <= rpResult;
                    overflowQ <= rpOverflow;
                    inexactQ  <= rpInexact;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValidQ;
    assign bus.result    = resultQ;
    assign bus.overflow  = overflowQ;
    assign bus.inexact   = inexactQ;

endmodule

// File: tb/tb_fp_add_normalize.sv
// tb_fp_add_normalize
// Directed bench for fp_add_normalize: expected results are queued when an
// operand set is accepted and compared when out_valid appears.
module tb_fp_add_normalize;

    logic clock = 1'b0;
    logic reset_n;

    fp_add_normalize_if bus();

    fp_add_normalize dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] result;
        logic        overflow;
        logic        inexact;
        int          latency;
    } expectT;

    expectT sbQueue[$];
    int     checks = 0;
    int     errors = 0;
    int     cycleCount = 0;
    int     acceptCycle = 0;

    // Free-running clock and a cycle counter used for latency measurement.
    always #5 clock = ~clock;
    always @(posedge clock) cycleCount++;

    // One comparison: counts it, and reports a mismatch on one line.
    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Offers one operand set starting at a negedge, queues its expectation
    // and returns just after the accepting edge.
    task automatic applyStimulus(input string tag, input logic sa, input logic sb,
                                 input logic [7:0] e, input logic [23:0] ma,
                                 input logic [23:0] mb, input logic g, input logic r,
                                 input logic s, input logic [31:0] expResult,
                                 input logic expOvf, input logic expInexact,
                                 input int expLatency);
        expectT item;
        int waitCount = 0;
        while (!bus.in_ready && waitCount < 50) begin
            @(negedge clock);
            waitCount++;
        end
        checkValue({tag, "-inReady"}, {31'd0, bus.in_ready}, 32'd1);
        bus.signA            = sa;
        bus.signB            = sb;
        bus.exponentIn       = e;
        bus.alignedMantissaA = ma;
        bus.alignedMantissaB = mb;
        bus.guardBit         = g;
        bus.roundBit         = r;
        bus.stickyBit        = s;
        bus.in_valid         = 1'b1;
        acceptCycle          = cycleCount;
        item.tag      = tag;
        item.result   = expResult;
        item.overflow = expOvf;
        item.inexact  = expInexact;
        item.latency  = expLatency;
        sbQueue.push_back(item);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, compares against the queue head, holds
    // out_ready low for holdCycles while checking stability, then accepts.
    task automatic checkOutput(input int holdCycles);
        expectT item;
        int waitCount = 0;
        @(negedge clock);
        while (!bus.out_valid && waitCount < 60) begin
            @(negedge clock);
            waitCount++;
        end
        if (sbQueue.size() == 0) begin
            checkValue("scoreboardEmpty", 32'd0, 32'd1);
            return;
        end
        item = sbQueue.pop_front();
        checkValue({item.tag, "-outValid"}, {31'd0, bus.out_valid}, 32'd1);
        checkValue({item.tag, "-latency"}, 32'(cycleCount - acceptCycle), 32'(item.latency));
        checkValue({item.tag, "-result"}, bus.result, item.result);
        checkValue({item.tag, "-overflow"}, {31'd0, bus.overflow}, {31'd0, item.overflow});
        checkValue({item.tag, "-inexact"}, {31'd0, bus.inexact}, {31'd0, item.inexact});
        checkValue({item.tag, "-busy"}, {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clock);
            checkValue({item.tag, "-holdResult"}, bus.result, item.result);
            checkValue({item.tag, "-holdValid"}, {31'd0, bus.out_valid}, 32'd1);
            checkValue({item.tag, "-holdBusy"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        checkValue({item.tag, "-released"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    endtask

    // Directed sequence: reset values, arithmetic cases, backpressure,
    // reset during normalization, reset colliding with a handshake.
    initial begin
        $display("[TB] fp_add_normalize bench starting");
        reset_n              = 1'b0;
        bus.in_valid         = 1'b0;
        bus.out_ready        = 1'b0;
        bus.signA            = 1'b0;
        bus.signB            = 1'b0;
        bus.exponentIn       = 8'd0;
        bus.alignedMantissaA = 24'd0;
        bus.alignedMantissaB = 24'd0;
        bus.guardBit         = 1'b0;
        bus.roundBit         = 1'b0;
        bus.stickyBit        = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkValue("resetInReady", {31'd0, bus.in_ready}, 32'd1);
        checkValue("resetOutValid", {31'd0, bus.out_valid}, 32'd0);
        checkValue("resetResult", bus.result, 32'd0);
        checkValue("resetOverflow", {31'd0, bus.overflow}, 32'd0);
        checkValue("resetInexact", {31'd0, bus.inexact}, 32'd0);

        applyStimulus("onePlusOne", 0, 0, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'h40000000, 0, 0, 3);
        checkOutput(0);
        applyStimulus("oneMinusOne", 0, 1, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'h00000000, 0, 0, 2);
        checkOutput(0);
        applyStimulus("normTwo", 0, 1, 8'd127, 24'hC00000, 24'hA00000, 0, 0, 0, 32'h3E800000, 0, 0, 5);
        checkOutput(0);
        applyStimulus("bLarger", 0, 1, 8'd127, 24'hA00000, 24'hC00000, 0, 0, 0, 32'hBE800000, 0, 0, 5);
        checkOutput(0);
        applyStimulus("tieEven", 0, 0, 8'd127, 24'h800000, 24'h000001, 1, 0, 0, 32'h3F800002, 0, 1, 3);
        checkOutput(5);
        applyStimulus("roundDown", 0, 0, 8'd127, 24'h800000, 24'h000001, 0, 1, 0, 32'h3F800001, 0, 1, 3);
        checkOutput(0);
        applyStimulus("roundCarry", 0, 0, 8'd127, 24'hFFFFFF, 24'h000000, 1, 1, 0, 32'h40000000, 0, 1, 3);
        checkOutput(0);
        applyStimulus("overflow", 0, 0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 32'h7F800000, 1, 0, 3);
        checkOutput(0);
        applyStimulus("denormSub", 0, 1, 8'd1, 24'h400000, 24'h300000, 0, 0, 0, 32'h00100000, 0, 0, 3);
        checkOutput(0);
        applyStimulus("zeroExp", 0, 0, 8'd0, 24'h000010, 24'h000008, 0, 0, 0, 32'h00000018, 0, 0, 3);
        checkOutput(0);
        applyStimulus("denormToNormal", 0, 0, 8'd0, 24'h7FFFFF, 24'h000000, 1, 1, 0, 32'h00800000, 0, 1, 3);
        checkOutput(0);
        applyStimulus("deepNorm", 0, 1, 8'd127, 24'h800000, 24'h7FFFFF, 0, 0, 0, 32'h34000000, 0, 0, 26);
        checkOutput(0);
        applyStimulus("negSame", 1, 1, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'hC0000000, 0, 0, 3);
        checkOutput(0);

        // Abort a long normalization part-way through with reset.
        applyStimulus("abortNorm", 0, 1, 8'd127, 24'h800000, 24'h7FFFFF, 0, 0, 0, 32'h34000000, 0, 0, 26);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkValue("abortOutValid", {31'd0, bus.out_valid}, 32'd0);
        checkValue("abortInReady", {31'd0, bus.in_ready}, 32'd1);
        checkValue("abortResult", bus.result, 32'd0);
        void'(sbQueue.pop_front());
        repeat (30) @(negedge clock);
        checkValue("abortStaysIdle", {31'd0, bus.out_valid}, 32'd0);

        // Reset asserted in the same cycle as an offered handshake.
        bus.signA            = 1'b0;
        bus.signB            = 1'b0;
        bus.exponentIn       = 8'd127;
        bus.alignedMantissaA = 24'h800000;
        bus.alignedMantissaB = 24'h800000;
        bus.in_valid         = 1'b1;
        reset_n              = 1'b0;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        @(negedge clock);
        checkValue("resetWinsReady", {31'd0, bus.in_ready}, 32'd1);
        repeat (5) @(negedge clock);
        checkValue("resetWinsNoOutput", {31'd0, bus.out_valid}, 32'd0);

        applyStimulus("recovery", 0, 0, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'h40000000, 0, 0, 3);
        checkOutput(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
